uart_param: RTL and testbench
=============================

# uart_param

Parametrised full-duplex UART: the successor to the fixed 8N1 UART core, with configurable data width, stop-bit count, and bit period. It also adds a metastability-hardened receive path, start-bit glitch rejection, framing-error reporting, and optional parity. It sits between the board-level `rxd`/`txd` pins and the byte-stream logic of the TPM interface.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per bit; legal range ≥ 4.
- `DATA_BITS`, 8: data bits per frame; legal range 5–9.
- `STOP_BITS`, 1: stop bits transmitted; 1 or 2. RX always checks exactly one stop bit.
- `DEBUG`, 0: when 1, the effective bit period is `uart_pkg::DEBUG_CLKS_PER_BIT` (5) and `CLKS_PER_BIT` is ignored.
- `ODD_PARITY`, 0: parity sense (0 = even, 1 = odd). Only meaningful with `UART_PARITY_EN`.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `rxd` in 1: asynchronous serial input; idles high.
- `txd` out 1: serial output; idles high.
- `rxData` out DATA_BITS: last received word. Stable until the next `dataValid`.
- `dataValid` out 1: one-cycle pulse; `rxData` and the error flags are valid on this cycle.
- `frameErr` out 1: the stop bit was sampled low. Qualified by `dataValid`.
- `parityErr` out 1: parity mismatch. Qualified by `dataValid`.
- `txData` in DATA_BITS: word to send. Sampled on an accepted `txSend`.
- `txSend` in 1: send request.
- `txReady` out 1: the transmitter is idle and will accept `txSend`.

## Operation
- Reset values: `txd`=1, `txReady`=1, `dataValid`=0, `rxData`=0, `frameErr`=0, `parityErr`=0. Both FSMs go to IDLE and all counters clear.
- Reset mid-frame aborts both directions. `txd` returns high on the cycle after reset is sampled, and no `dataValid` is produced for the partial frame.
- Let P = bit period (5 if `DEBUG`, else `CLKS_PER_BIT`).
- RX synchroniser: `rxd` passes through a 2-flop synchroniser, so all RX decisions use `rxs`, which lags `rxd` by 2 cycles.
- RX FSM, IDLE → START: taken when `rxs`=0.
- RX FSM, START: count floor(P/2) cycles.
  - If `rxs` is still 0 → DATA.
  - Otherwise → IDLE (glitch rejected; no output).
- RX FSM, DATA: sample `rxs` every P cycles, LSB first, into a shift register for `DATA_BITS` samples. Then go to PARITY if it is compiled in, else to STOP.
- RX FSM, PARITY: take one sample after P cycles and compare it against the computed parity.
- RX FSM, STOP: take one sample after P cycles.
  - Update `rxData`, pulse `dataValid`, and set `frameErr`=~sample and `parityErr` accordingly.
  - If the sample was 1 → IDLE.
  - If the sample was 0 → BREAK.
- RX FSM, BREAK: wait for `rxs`=1, then → IDLE. No new frame is recognised during a line break.
- TX FSM, IDLE: `txReady`=1. On `txSend`&`txReady`, latch `txData`; `txReady` falls on the next cycle.
- TX frame contents, in order, each bit held for P cycles:
  - start bit (0);
  - `DATA_BITS` data bits, LSB first;
  - the parity bit, if enabled;
  - `STOP_BITS` stop bits (1).
- TX return: → IDLE, with `txReady`=1 on the cycle after the last stop-bit cycle.
- `txSend` while `txReady`=0 is ignored, not queued.
- RX and TX are fully independent, so simultaneous activity in both directions is legal.

## Timing
- TX latency: the start bit appears on `txd` in the cycle after `txSend` is accepted.
- TX frame length: F = P·(1 + `DATA_BITS` + p + `STOP_BITS`) cycles, where p = 1 with parity and 0 without.
- TX back-to-back: `txReady` is low for exactly F cycles.
- RX latency: `dataValid` pulses 2 + floor(P/2) + P·(`DATA_BITS` + p + 1) cycles after the first cycle `rxd` is low.
- Bit timer: a single down-counter of width $clog2(P), reloaded on every bit boundary. Bit counter width is $clog2(`DATA_BITS`+1).
- No combinational path from any input to any output.

## Configuration
- Macro: `UART_PARITY_EN`.
- Defined:
  - a parity bit follows the data bits in both directions;
  - parity is even XOR over the data when `ODD_PARITY`=0, inverted when `ODD_PARITY`=1;
  - `parityErr` is driven by the RX parity check.
- Undefined: the PARITY states do not exist, frames carry no parity bit, and `parityErr` is tied 0.

## Structure
- `uart_pkg` holds:
  - `rx_state_t` (IDLE, START, DATA, PARITY, STOP, BREAK);
  - `tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - `DEBUG_CLKS_PER_BIT`=5.
- Sub-module `uart_bit_timer`: a reloadable down-counter with a `tick` output. Two instances: one for RX, one for TX.

## Test plan
All scenarios use `DEBUG`=1 (P=5), `DATA_BITS`=8, `STOP_BITS`=1 unless stated otherwise.
- **Reset:** assert `reset` for 2 cycles mid-TX frame → `txd`=1, `txReady`=1 next cycle, and all RX outputs 0.
- **Clean RX:** drive 0x00 with a valid stop bit → a single `dataValid` pulse 49 cycles after the `rxd` falling edge; `rxData`=0x00, `frameErr`=0.
- **Framing error:** drive 0xA5 with the stop bit held 0 for 20 cycles → `dataValid` with `rxData`=0xA5 and `frameErr`=1. No further `dataValid` until `rxd` rises, then a following 0x3C frame is received correctly.
- **Glitch rejection:** pulse `rxd` low for 2 cycles → no `dataValid`, and the RX FSM returns to IDLE.
- **TX:** send 0x3C with `STOP_BITS`=2 → `txd` = 0, 0,0,1,1,1,1,0,0, 1,1, each bit 5 cycles. `txReady` is low for 55 cycles, and a `txSend` at cycle 10 of the frame is ignored.
- **Parity** (`UART_PARITY_EN`, `ODD_PARITY`=0):
  - TX 0x07 → parity bit 1.
  - RX 0x07 with parity bit 0 → `parityErr`=1.
  - RX 0x07 with parity bit 1 → `parityErr`=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART.
// Optional parity support is compiled in with the UART_PARITY_EN macro.
package uart_pkg;

    localparam int DEBUG_CLKS_PER_BIT = 5;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    // Effective bit period: the debug build runs at a short fixed period.
    function automatic int bitPeriod(input int debug, input int clksPerBit);
        return (debug != 0) ? DEBUG_CLKS_PER_BIT : clksPerBit;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Reloadable bit-period down-counter. tick is high while the count is zero;
// a tick auto-reloads PERIOD-1, and load overrides with an arbitrary value.
// A load of value L therefore produces a tick L+1 cycles later.
module uart_bit_timer #(
    parameter int PERIOD = 5,
    parameter int W      = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] loadVal,
    output logic         tick
);

    logic [W-1:0] cnt;

    assign tick = (cnt == '0);

    // Count down, reload on every bit boundary or on an explicit load.
    always_ff @(posedge clk) begin
        if (reset)     cnt <= '0;
        else if (load) cnt <= loadVal;
        else if (tick) cnt <= W'(PERIOD - 1);
        else           cnt <= cnt - 1'b1;
    end

endmodule

// File: rtl/uart_param.sv
// Parametrised full-duplex UART with synchronised, glitch-filtered RX,
// framing-error reporting and a line-break hold state.
// Define UART_PARITY_EN to add a parity bit in both directions.
module uart_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int DEBUG        = 0,
    parameter int ODD_PARITY   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    output logic                 txd,
    output logic [DATA_BITS-1:0] rxData,
    output logic                 dataValid,
    output logic                 frameErr,
    output logic                 parityErr,
    input  logic [DATA_BITS-1:0] txData,
    input  logic                 txSend,
    output logic                 txReady
);

    localparam int P  = bitPeriod(DEBUG, CLKS_PER_BIT);
    localparam int TW = $clog2(P);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] RELOAD = TW'(P - 1);
    localparam logic [TW-1:0] HALF   = TW'(P / 2 - 1);
    localparam logic [BW-1:0] LAST   = BW'(DATA_BITS - 1);

    // ---------------- RX ----------------
    rx_state_t            rxState, rxNext;
    logic                 rxMeta, rxs;
    logic                 rxLoad, rxTick;
    logic [TW-1:0]        rxLoadVal;
    logic [BW-1:0]        rxCnt;
    logic [DATA_BITS-1:0] rxSh;

    uart_bit_timer #(.PERIOD(P), .W(TW)) rxTimer (
        .clk(clk), .reset(reset), .load(rxLoad), .loadVal(rxLoadVal), .tick(rxTick)
    );

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxMeta <= 1'b1;
            rxs    <= 1'b1;
        end else begin
            rxMeta <= rxd;
            rxs    <= rxMeta;
        end
    end

    // RX state register.
    always_ff @(posedge clk) begin
        if (reset) rxState <= RX_IDLE;
        else       rxState <= rxNext;
    end

    // RX next state; the half-period load centres samples mid-bit.
    always_comb begin
        rxNext    = rxState;
        rxLoad    = 1'b0;
        rxLoadVal = RELOAD;
        case (rxState)
            RX_IDLE: if (!rxs) begin
                rxNext    = RX_START;
                rxLoad    = 1'b1;
                rxLoadVal = HALF;
            end
            RX_START: if (rxTick) begin
                if (!rxs) begin
                    rxNext = RX_DATA;
                    rxLoad = 1'b1;
                end else begin
                    rxNext = RX_IDLE;
                end
            end
`ifdef UART_PARITY_EN
            RX_DATA:   if (rxTick && rxCnt == LAST) rxNext = RX_PARITY;
            RX_PARITY: if (rxTick) rxNext = RX_STOP;
`else
            RX_DATA:   if (rxTick && rxCnt == LAST) rxNext = RX_STOP;
`endif
            RX_STOP:  if (rxTick) rxNext = rxs ? RX_IDLE : RX_BREAK;
            RX_BREAK: if (rxs) rxNext = RX_IDLE;
            default:  rxNext = RX_IDLE;
        endcase
    end

`ifdef UART_PARITY_EN
    logic rxParBit;
`endif

    // RX datapath: shift in data LSB first, publish the word at the stop sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxCnt     <= '0;
            rxSh      <= '0;
            rxData    <= '0;
            dataValid <= 1'b0;
            frameErr  <= 1'b0;
`ifdef UART_PARITY_EN
            rxParBit  <= 1'b0;
            parityErr <= 1'b0;
`endif
        end else begin
            dataValid <= 1'b0;
            case (rxState)
                RX_START: rxCnt <= '0;
                RX_DATA: if (rxTick) begin
                    rxSh  <= {rxs, rxSh[DATA_BITS-1:1]};
                    rxCnt <= rxCnt + 1'b1;
                end
`ifdef UART_PARITY_EN
                RX_PARITY: if (rxTick) rxParBit <= rxs;
`endif
                RX_STOP: if (rxTick) begin
                    rxData    <= rxSh;
                    dataValid <= 1'b1;
                    frameErr  <= ~rxs;
`ifdef UART_PARITY_EN
                    parityErr <= (^rxSh) ^ (ODD_PARITY != 0) ^ rxParBit;
`endif
                end
                default: ;
            endcase
        end
    end

`ifndef UART_PARITY_EN
    assign parityErr = 1'b0;
`endif

    // ---------------- TX ----------------
    tx_state_t            txState, txNext;
    logic                 txLoad, txTick;
    logic [BW-1:0]        txCnt;
    logic [DATA_BITS-1:0] txSh;
    logic                 stopCnt;
`ifdef UART_PARITY_EN
    logic                 txPar;
`endif

    uart_bit_timer #(.PERIOD(P), .W(TW)) txTimer (
        .clk(clk), .reset(reset), .load(txLoad), .loadVal(RELOAD), .tick(txTick)
    );

    assign txReady = (txState == TX_IDLE);

    // TX state register.
    always_ff @(posedge clk) begin
        if (reset) txState <= TX_IDLE;
        else       txState <= txNext;
    end

    // TX next state; a request outside IDLE is dropped.
    always_comb begin
        txNext = txState;
        txLoad = 1'b0;
        case (txState)
            TX_IDLE: if (txSend) begin
                txNext = TX_START;
                txLoad = 1'b1;
            end
            TX_START: if (txTick) txNext = TX_DATA;
`ifdef UART_PARITY_EN
            TX_DATA:   if (txTick && txCnt == LAST) txNext = TX_PARITY;
            TX_PARITY: if (txTick) txNext = TX_STOP;
`else
            TX_DATA:   if (txTick && txCnt == LAST) txNext = TX_STOP;
`endif
            TX_STOP: if (txTick && stopCnt == 1'(STOP_BITS - 1)) txNext = TX_IDLE;
            default: txNext = TX_IDLE;
        endcase
    end

    // TX datapath: txd is registered and updated on each bit boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            txd     <= 1'b1;
            txSh    <= '0;
            txCnt   <= '0;
            stopCnt <= 1'b0;
`ifdef UART_PARITY_EN
            txPar   <= 1'b0;
`endif
        end else begin
            case (txState)
                TX_IDLE: if (txSend) begin
                    txSh    <= txData;
                    txd     <= 1'b0;
                    txCnt   <= '0;
                    stopCnt <= 1'b0;
`ifdef UART_PARITY_EN
                    txPar   <= (^txData) ^ (ODD_PARITY != 0);
`endif
                end
                TX_START: if (txTick) begin
                    txd  <= txSh[0];
                    txSh <= {1'b0, txSh[DATA_BITS-1:1]};
                end
                TX_DATA: if (txTick) begin
                    if (txCnt == LAST) begin
`ifdef UART_PARITY_EN
                        txd <= txPar;
`else
                        txd <= 1'b1;
`endif
                    end else begin
                        txd   <= txSh[0];
                        txSh  <= {1'b0, txSh[DATA_BITS-1:1]};
                        txCnt <= txCnt + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                TX_PARITY: if (txTick) txd <= 1'b1;
`endif
                TX_STOP: if (txTick) stopCnt <= stopCnt + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_param.sv
// Directed bench for uart_param at P=5, 8 data bits, 2 TX stop bits.
module tb_uart_param;

    localparam int P = 5;
`ifdef UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB  = 8 + PB;                    // RX bits after start, before stop
    localparam int LAT = 2 + P / 2 + P * (8 + PB + 1);
    localparam int TXB = 1 + 8 + PB + 2;            // TX bits per frame

    logic       clk = 1'b0;
    logic       reset, rxd, txSend;
    logic [7:0] txData;
    logic       txd, dataValid, frameErr, parityErr, txReady;
    logic [7:0] rxData;

    int nVec = 0;
    int nMis = 0;

    uart_param #(.CLKS_PER_BIT(868), .DATA_BITS(8), .STOP_BITS(2), .DEBUG(1), .ODD_PARITY(0)) dut (
        .clk(clk), .reset(reset), .rxd(rxd), .txd(txd), .rxData(rxData),
        .dataValid(dataValid), .frameErr(frameErr), .parityErr(parityErr),
        .txData(txData), .txSend(txSend), .txReady(txReady)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive start, NB frame bits, then the stop level for stopCyc cycles; monitor dataValid.
    task automatic rxFrame(input logic [8:0] bits, input logic stopVal, input int stopCyc,
                           output int pulses, output int lat, output logic [7:0] gotD,
                           output logic gotFe, output logic gotPe);
        int window;
        window = P * (1 + NB) + stopCyc + 10;
        pulses = 0; lat = -1; gotD = '0; gotFe = 1'b0; gotPe = 1'b0;
        rxd = 1'b0;
        fork
            begin
                repeat (P) step();
                for (int i = 0; i < NB; i++) begin
                    rxd = bits[i];
                    repeat (P) step();
                end
                rxd = stopVal;
                repeat (stopCyc) step();
                rxd = 1'b1;
            end
            begin
                for (int n = 1; n <= window; n++) begin
                    step();
                    if (dataValid) begin
                        if (pulses == 0) begin
                            lat = n - 1; gotD = rxData; gotFe = frameErr; gotPe = parityErr;
                        end
                        pulses++;
                    end
                end
            end
        join
    endtask

    // Send one word and compare every txd cycle against the hand-built frame.
    task automatic txFrame(input logic [7:0] d, input logic [11:0] expBits);
        int k;
        logic stayIdle;
        k = 0;
        while (!txReady && k < 200) begin step(); k++; end
        check("tx_ready_before", txReady, 1'b1);
        txData = d; txSend = 1'b1;
        step();
        for (int j = 0; j < TXB * P; j++) begin
            check($sformatf("txd_%0h_cyc%0d", d, j), txd, expBits[j / P]);
            check($sformatf("txready_low_cyc%0d", j), txReady, 1'b0);
            if (j == 10) begin txSend = 1'b1; txData = 8'hFF; end
            else txSend = 1'b0;
            step();
        end
        check("tx_ready_return", txReady, 1'b1);
        stayIdle = 1'b1;
        for (int j = 0; j < 10; j++) begin
            if (txd !== 1'b1 || txReady !== 1'b1) stayIdle = 1'b0;
            step();
        end
        check("tx_ignored_send", stayIdle, 1'b1);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       pb;
        logic       stopVal;
        int         stopCyc;
        logic [7:0] expD;
        logic       expFe;
        logic       expPe;
    } rxvec_t;

    rxvec_t vt[6];
    int pulses, lat;
    logic [7:0] gotD;
    logic gotFe, gotPe;

    initial begin
        vt[0] = '{8'h00, 1'b0, 1'b1, 5,  8'h00, 1'b0, 1'b0};
        vt[1] = '{8'hA5, 1'b0, 1'b0, 20, 8'hA5, 1'b1, 1'b0};
        vt[2] = '{8'h3C, 1'b0, 1'b1, 5,  8'h3C, 1'b0, 1'b0};
        vt[3] = '{8'h01, 1'b1, 1'b1, 5,  8'h01, 1'b0, 1'b0};
`ifdef UART_PARITY_EN
        vt[4] = '{8'h07, 1'b0, 1'b1, 5,  8'h07, 1'b0, 1'b1};
`else
        vt[4] = '{8'h07, 1'b0, 1'b1, 5,  8'h07, 1'b0, 1'b0};
`endif
        vt[5] = '{8'h07, 1'b1, 1'b1, 5,  8'h07, 1'b0, 1'b0};

        reset = 1'b1; rxd = 1'b1; txSend = 1'b0; txData = '0;
        repeat (3) step();
        check("rst_txd", txd, 1'b1);
        check("rst_txready", txReady, 1'b1);
        check("rst_datavalid", dataValid, 1'b0);
        check("rst_rxdata", rxData, 8'h00);
        check("rst_frameerr", frameErr, 1'b0);
        check("rst_parityerr", parityErr, 1'b0);
        reset = 1'b0;
        repeat (5) step();

        // RX vector table
        for (int v = 0; v < 6; v++) begin
            rxFrame({vt[v].pb, vt[v].d}, vt[v].stopVal, vt[v].stopCyc, pulses, lat, gotD, gotFe, gotPe);
            check($sformatf("rx%0d_pulses", v), pulses, 1);
            check($sformatf("rx%0d_latency", v), lat, LAT);
            check($sformatf("rx%0d_data", v), gotD, vt[v].expD);
            check($sformatf("rx%0d_frameerr", v), gotFe, vt[v].expFe);
            check($sformatf("rx%0d_parityerr", v), gotPe, vt[v].expPe);
            repeat (5) step();
        end

        // Glitch: two cycles low must be rejected, then a normal frame still lands.
        rxd = 1'b0; step(); step(); rxd = 1'b1;
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (dataValid) pulses++;
        end
        check("glitch_no_valid", pulses, 0);
        rxFrame({1'b0, 8'h5A}, 1'b1, 5, pulses, lat, gotD, gotFe, gotPe);
        check("post_glitch_latency", lat, LAT);
        check("post_glitch_data", gotD, 8'h5A);

        // TX frames: start, data LSB first, [parity], two stop bits
`ifdef UART_PARITY_EN
        txFrame(8'h3C, 12'b11_0_00111100_0);
        txFrame(8'h07, 12'b11_1_00000111_0);
`else
        txFrame(8'h3C, 12'b0_11_00111100_0);
        txFrame(8'h07, 12'b0_11_00000111_0);
`endif

        // Reset mid-frame in both directions after leaving error state visible.
        rxFrame({1'b0, 8'hA5}, 1'b0, 20, pulses, lat, gotD, gotFe, gotPe);
        check("pre_reset_frameerr", gotFe, 1'b1);
        repeat (5) step();
        txData = 8'h55; txSend = 1'b1; rxd = 1'b0;
        step();
        txSend = 1'b0;
        repeat (20) step();
        reset = 1'b1;
        step();
        check("reset_txd_next", txd, 1'b1);
        check("reset_txready_next", txReady, 1'b1);
        step();
        reset = 1'b0; rxd = 1'b1;
        check("reset_txd", txd, 1'b1);
        check("reset_rxdata", rxData, 8'h00);
        check("reset_frameerr", frameErr, 1'b0);
        check("reset_parityerr", parityErr, 1'b0);
        check("reset_datavalid", dataValid, 1'b0);
        pulses = 0;
        for (int n = 0; n < 60; n++) begin
            if (dataValid) pulses++;
            step();
        end
        check("reset_no_partial_valid", pulses, 0);
        check("reset_txd_idle", txd, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
